// File: rtl/lsu_pkg.sv
// Shared constants and types for the M-stage load/store unit.
// RV32I funct3 encodings for memory accesses and the LSU transaction states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: store strobes and lane replication,
// load byte/half selection with sign or zero extension, and access-fault detection.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] raw_rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        fault
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = raw_rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = raw_rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: every output is given a default first so no path through the cases infers a latch.
        wstrb     = 4'b0000;
        wdata     = store_data;
        load_data = '0;
        fault     = 1'b0;
        if (is_store) begin
            case (funct3)
                F3_B: begin
                    wstrb = 4'b0001 << addr_lo;
                    wdata = {4{store_data[7:0]}};
                end
                F3_H: begin
                    wstrb = 4'b0011 << addr_lo;
                    wdata = {2{store_data[15:0]}};
                    fault = addr_lo[0];
                end
                F3_W: begin
                    wstrb = 4'b1111;
                    fault = |addr_lo;
                end
                default: fault = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
                F3_BU: load_data = {24'd0, byte_sel};
                F3_H: begin
                    load_data = {{16{half_sel[15]}}, half_sel};
                    fault     = addr_lo[0];
                end
                F3_HU: begin
                    load_data = {16'd0, half_sel};
                    fault     = addr_lo[0];
                end
                F3_W: begin
                    load_data = raw_rdata;
                    fault     = |addr_lo;
                end
                default: fault = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// M-stage load/store unit: drives a req/gnt/rvalid data bus, stalls the pipeline
// while a transaction is outstanding and buffers a finished result while held.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MemWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic [2:0]      funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic            hold_i,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] ReadDataM,
    output logic            stall_o,
    output logic            misaligned_o
);

    lsu_state_t      state_q, state_d;
    logic [XLEN-1:0] buf_q;
    logic [XLEN-1:0] lane_wdata, load_data, result_data;
    logic [3:0]      lane_wstrb;
    logic            fault, op_present, is_load, legal, issue, complete;

    lsu_align u_align (
        .is_store   (MemWriteM),
        .funct3     (funct3M),
        .addr_lo    (ALUResultM[1:0]),
        .store_data (WriteDataM),
        .raw_rdata  (dmem_rdata),
        .wstrb      (lane_wstrb),
        .wdata      (lane_wdata),
        .load_data  (load_data),
        .fault      (fault)
    );

    assign is_load    = ~MemWriteM & (ResultSrcM == RESULT_SRC_MEM);
    assign op_present = MemWriteM | (ResultSrcM == RESULT_SRC_MEM);
    assign legal      = op_present & ~fault;

    // Outputs are gated by reset so they drop to zero the moment reset rises.
    assign issue    = ~reset & legal & ((state_q == IDLE) | (state_q == REQ));
    assign complete = ~reset & ((issue & dmem_gnt & MemWriteM) |
                                ((state_q == RESP) & dmem_rvalid));

    assign dmem_req     = issue;
    assign dmem_we      = issue & MemWriteM;
    assign dmem_addr    = issue ? {ALUResultM[XLEN-1:2], 2'b00} : '0;
    assign dmem_wdata   = dmem_we ? lane_wdata : '0;
    assign dmem_wstrb   = dmem_we ? lane_wstrb : 4'b0000;
    assign result_data  = is_load ? load_data : '0;
    assign stall_o      = ~reset & legal & ~complete & (state_q != DONE);
    assign misaligned_o = ~reset & op_present & fault;

    always_comb begin
        ReadDataM = '0;
        if (!reset) begin
            if (state_q == DONE) ReadDataM = buf_q;
            else if (complete)   ReadDataM = result_data;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, REQ: begin
                if (issue) begin
                    if (!dmem_gnt)      state_d = REQ;
                    else if (MemWriteM) state_d = hold_i ? DONE : IDLE;
                    else                state_d = RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: if (dmem_rvalid) state_d = hold_i ? DONE : IDLE;
            DONE: if (!hold_i)     state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            if (complete && hold_i) buf_q <= result_data;
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed scenarios plus random transactions
// checked against a byte-level reference model of the access rules.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic        hold_i;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata, ReadDataM;
    logic        stall_o, misaligned_o;

    int checks = 0;
    int errors = 0;

    lsu_mem_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .MemWriteM    (MemWriteM),
        .ResultSrcM   (ResultSrcM),
        .funct3M      (funct3M),
        .ALUResultM   (ALUResultM),
        .WriteDataM   (WriteDataM),
        .hold_i       (hold_i),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_wstrb   (dmem_wstrb),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .ReadDataM    (ReadDataM),
        .stall_o      (stall_o),
        .misaligned_o (misaligned_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes and the rules derived from it.
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
        if (st && f3 > 3'd2) return 1'b1;
        if (!st && (f3 == 3'd3 || f3 >= 3'd6)) return 1'b1;
        return (a % nbytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] a);
        int m;
        m = ((1 << nbytes(f3)) - 1) << a[1:0];
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(f3)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v, mask;
        int n;
        n = nbytes(f3);
        v = rd >> (8 * a[1:0]);
        if (n < 4) begin
            mask = (32'h1 << (8 * n)) - 32'h1;
            v = v & mask;
            if (!f3[2] && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic drive_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd);
        MemWriteM  = st;
        ResultSrcM = st ? 2'b00 : 2'b01;
        funct3M    = f3;
        ALUResultM = a;
        WriteDataM = wd;
    endtask

    task automatic clear_op();
        MemWriteM   = 1'b0;
        ResultSrcM  = 2'b00;
        funct3M     = 3'd0;
        ALUResultM  = '0;
        WriteDataM  = '0;
        hold_i      = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One legal transaction: gd cycles before gnt, rd_dly extra cycles before rvalid,
    // hold_n cycles of hold_i counted from the completion cycle (0 = no hold).
    task automatic run_op(input string tag, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input int gd, input int rd_dly, input int hold_n);
        logic [31:0] el;
        el = exp_load(f3, a, rd);
        drive_op(st, f3, a, wd);
        dmem_rdata = rd;
        hold_i = (hold_n > 0);
        for (int c = 0; c <= gd; c++) begin
            dmem_gnt    = (c == gd);
            dmem_rvalid = 1'($urandom);
            #1;
            check({tag, ".req"}, dmem_req, 1'b1);
            check({tag, ".we"}, dmem_we, st);
            check({tag, ".addr"}, dmem_addr, {a[31:2], 2'b00});
            check({tag, ".wstrb"}, dmem_wstrb, st ? exp_strb(f3, a) : 4'b0000);
            if (st) check({tag, ".wdata"}, dmem_wdata, exp_wdata(f3, wd));
            check({tag, ".stall"}, stall_o, !(st && c == gd));
            check({tag, ".mis"}, misaligned_o, 1'b0);
            next_cycle();
        end
        if (!st) begin
            for (int r = 0; r <= rd_dly; r++) begin
                dmem_gnt    = 1'($urandom);
                dmem_rvalid = (r == rd_dly);
                #1;
                check({tag, ".resp_req"}, dmem_req, 1'b0);
                check({tag, ".resp_stall"}, stall_o, r != rd_dly);
                if (r == rd_dly) check({tag, ".rdata"}, ReadDataM, el);
                next_cycle();
            end
        end
        for (int h = 1; h <= hold_n; h++) begin
            hold_i      = (h < hold_n);
            dmem_gnt    = 1'($urandom);
            dmem_rvalid = 1'($urandom);
            #1;
            check({tag, ".done_req"}, dmem_req, 1'b0);
            check({tag, ".done_stall"}, stall_o, 1'b0);
            if (!st) check({tag, ".done_data"}, ReadDataM, el);
            next_cycle();
        end
        clear_op();
        #1;
        check({tag, ".idle_req"}, dmem_req, 1'b0);
        check({tag, ".idle_stall"}, stall_o, 1'b0);
        check({tag, ".idle_data"}, ReadDataM, 32'h0);
        next_cycle();
    endtask

    task automatic fault_op(input string tag, input bit st, input logic [2:0] f3,
                            input logic [31:0] a);
        drive_op(st, f3, a, $urandom);
        dmem_gnt   = 1'($urandom);
        dmem_rdata = $urandom;
        #1;
        check({tag, ".mis"}, misaligned_o, 1'b1);
        check({tag, ".req"}, dmem_req, 1'b0);
        check({tag, ".stall"}, stall_o, 1'b0);
        check({tag, ".data"}, ReadDataM, 32'h0);
        check({tag, ".wstrb"}, dmem_wstrb, 4'b0000);
        next_cycle();
        clear_op();
        next_cycle();
    endtask

    initial begin
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [2:0]  load_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        reset = 1'b1;
        clear_op();
        dmem_rdata = '0;
        next_cycle();
        drive_op(1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
        dmem_gnt = 1'b1;
        #1;
        check("reset.req", dmem_req, 1'b0);
        check("reset.stall", stall_o, 1'b0);
        check("reset.data", ReadDataM, 32'h0);
        check("reset.wstrb", dmem_wstrb, 4'b0000);
        next_cycle();
        clear_op();
        reset = 1'b0;
        next_cycle();

        run_op("sw",  1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 0);
        run_op("lb",  1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_7F01, 0, 0, 0);
        run_op("lbu", 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_7F01, 0, 0, 0);
        run_op("sh",  1'b1, 3'd1, 32'h202, 32'h0000ABCD, 32'h0, 3, 0, 0);
        fault_op("lw_mis", 1'b0, 3'd2, 32'h101);
        run_op("lhu_hold", 1'b0, 3'd5, 32'h006, 32'h0, 32'h1234_5678, 0, 0, 2);
        run_op("sb_hold", 1'b1, 3'd0, 32'h011, 32'h0000_00A5, 32'h0, 1, 0, 2);
        fault_op("sh_mis", 1'b1, 3'd1, 32'h203);
        fault_op("ld_f3_6", 1'b0, 3'd6, 32'h000);
        fault_op("st_f3_3", 1'b1, 3'd3, 32'h000);

        // Reset while a load waits for its response; the late rvalid must be dropped.
        drive_op(1'b0, 3'd2, 32'h40, 32'h0);
        dmem_gnt = 1'b1;
        #1;
        check("rst_mid.req", dmem_req, 1'b1);
        next_cycle();
        dmem_gnt = 1'b0;
        #1;
        check("rst_mid.resp_stall", stall_o, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_mid.stall", stall_o, 1'b0);
        check("rst_mid.req0", dmem_req, 1'b0);
        check("rst_mid.addr", dmem_addr, 32'h0);
        check("rst_mid.data", ReadDataM, 32'h0);
        next_cycle();
        reset = 1'b0;
        clear_op();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_F00D;
        #1;
        check("rst_late.data", ReadDataM, 32'h0);
        check("rst_late.stall", stall_o, 1'b0);
        next_cycle();
        run_op("rst_next", 1'b0, 3'd1, 32'h42, 32'h0, 32'hBEEF_8001, 0, 1, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                do begin
                    st = 1'($urandom);
                    f3 = 3'($urandom_range(0, 7));
                    a  = $urandom;
                end while (!model_fault(st, f3, a));
                fault_op("rnd_fault", st, f3, a);
            end else begin
                st = 1'($urandom);
                f3 = st ? 3'($urandom_range(0, 2)) : load_f3[$urandom_range(0, 4)];
                a  = $urandom & ~32'(nbytes(f3) - 1);
                run_op("rnd", st, f3, a, $urandom, $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
